// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro IF_PERF_CNT_EN is consumed by if_fetch_unit.
package if_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OPCODE_W     = 7;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPCODE_W-1:0] R_TYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] BRANCH = 7'b1100011;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_t;

    // Saturating 32-bit accumulate used by the event counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module if_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against current occupancy.
    always_comb begin
        empty     = (count_r == {CW{1'b0}});
        full      = (count_r == CNT_MAX);
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        count     = count_r;
        if (empty) begin
            rdata = {W{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while not counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, {pc,instr} buffer and redirect handling.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_killed event counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}},
    parameter int               DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [XLEN-1:0]     id_instr,
    output logic [XLEN-1:0]     id_pc,
    output logic [OPCODE_W-1:0] id_opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_killed
`endif
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam int              FW       = 2 * XLEN;
    localparam logic [CW:0]     DEPTH_L  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] PC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    if_state_t       state_r;
    logic [XLEN-1:0] pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   kill_cnt_r;

    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic [FW-1:0]   fifo_rdata_s;
    logic [FW-1:0]   fifo_wdata_s;
    logic [CW:0]     occ_s;
    logic            id_valid_s;
    logic            pop_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            rsp_ok_s;
    logic            push_s;
    logic            discard_s;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [XLEN-1:0] rsp_pc_s;

    // Handshake, credit and response classification.
    always_comb begin
        id_valid_s = !fifo_empty_s && !redirect_valid;
        pop_s      = id_valid_s && id_ready;
        // A slot freed by a pop this cycle can already be re-requested.
        occ_s = {1'b0, outstanding_r} + {1'b0, fifo_count_s} - {{CW{1'b0}}, pop_s};
        if ((state_r == RUN) && !redirect_valid && (occ_s < DEPTH_L)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s  = req_valid_s && imem_req_ready;
        rsp_ok_s  = imem_rsp_valid && (outstanding_r != {CW{1'b0}});
        push_s    = rsp_ok_s && (kill_cnt_r == {CW{1'b0}}) && !redirect_valid;
        discard_s = rsp_ok_s && !push_s;
        outstanding_nxt_s = outstanding_r + {{(CW-1){1'b0}}, accept_s}
                                          - {{(CW-1){1'b0}}, rsp_ok_s};
        // Live requests are consecutive words ending just below pc_r.
        rsp_pc_s     = pc_r - {{(XLEN-CW-2){1'b0}}, outstanding_r, 2'b00};
        fifo_wdata_s = {rsp_pc_s, imem_rsp_data};
    end

    // Control FSM, PC and in-flight bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            kill_cnt_r    <= {CW{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            case (state_r)
                BOOT:    state_r <= RUN;
                RUN:     state_r <= RUN;
                default: state_r <= BOOT;
            endcase
            if (redirect_valid) begin
                pc_r       <= redirect_pc & PC_MASK;
                kill_cnt_r <= outstanding_nxt_s;
            end else begin
                if (accept_s) begin
                    pc_r <= pc_r + PC_STEP;
                end
                if (rsp_ok_s && (kill_cnt_r != {CW{1'b0}})) begin
                    kill_cnt_r <= kill_cnt_r - CNT_ONE;
                end
            end
        end
    end

    if_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push_s),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign id_valid       = id_valid_s;
    assign id_pc          = fifo_rdata_s[FW-1:XLEN];
    assign id_instr       = fifo_rdata_s[XLEN-1:0];
    assign id_opcode      = fifo_rdata_s[OPCODE_W-1:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] kill_inc_s;

    // Kills are late responses plus buffered entries dropped by a redirect.
    always_comb begin
        if (redirect_valid) begin
            kill_inc_s = {31'h0, discard_s} + 32'(fifo_count_s);
        end else begin
            kill_inc_s = {31'h0, discard_s};
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= 32'h0;
            perf_killed  <= 32'h0;
        end else begin
            perf_fetched <= sat_add32(perf_fetched, {31'h0, push_s});
            perf_killed  <= sat_add32(perf_killed, kill_inc_s);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: scoreboard of accepted requests versus decode output,
// with an in-order memory model of configurable latency.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_t;

    exp_t        sb_q[$];
    mem_t        mem_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_addr;
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          last_due;
    int          mem_lat;
    int          pop_cnt;

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], a[8:2]} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [31:0] get_log(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_log(input int n, input string tag);
        int k;
        k = 0;
        while (pop_log.size() < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        check_eq({tag, "_req_addr"}, imem_req_addr, 32'h0);
        check_eq({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
        check_eq({tag, "_id_instr"}, id_instr, 32'h0);
        check_eq({tag, "_id_pc"}, id_pc, 32'h0);
        check_eq({tag, "_id_opcode"}, {25'h0, id_opcode}, 32'h0);
    endtask

    // Memory model: responses appear #1 after the edge, in order, one per cycle.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        cyc            = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    // Monitor: scoreboard pops, request address model, accept bookkeeping, flushes.
    initial begin
        exp_t e;
        mem_t m;
        exp_addr = 32'h0;
        last_due = 0;
        pop_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                mem_q.delete();
                last_due = 0;
                exp_addr = 32'h0;
            end else begin
                if (id_valid && id_ready) begin
                    pop_cnt++;
                    pop_log.push_back(id_pc);
                    check_eq("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_eq("id_pc", id_pc, e.pc);
                        check_eq("id_instr", id_instr, e.instr);
                        check_eq("id_opcode", {25'h0, id_opcode}, {25'h0, e.instr[6:0]});
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    check_eq("req_addr", imem_req_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                    m.addr   = imem_req_addr;
                    m.due    = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
                    last_due = m.due;
                    mem_q.push_back(m);
                    sb_q.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
                end
                if (redirect_valid) begin
                    sb_q.delete();
                    exp_addr = redirect_pc & 32'hFFFF_FFFC;
                end
            end
        end
    end

    initial begin
        int k;
        bit found;
        n_tests        = 0;
        n_fail         = 0;
        mem_lat        = 1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");

        // Reset release: first id_valid three cycles later, then one per cycle.
        @(posedge clk);
        #1 rst_n = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (id_valid) break;
            k++;
        end
        check_eq("first_valid_cycle", 32'(k), 32'd3);
        check_eq("first_id_pc", id_pc, 32'h0);
        @(posedge clk);
        #1;
        pop_cnt = 0;
        pop_log.delete();
        repeat (8) @(posedge clk);
        #1;
        check_eq("throughput", 32'(pop_cnt), 32'd8);
        for (int i = 0; i < 8; i++) check_eq("seq_pc", get_log(i), 32'(4 * (i + 1)));

        // Mid-stream reset, then decode stalled: exactly two entries buffered.
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        id_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk);
        check_eq("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_eq("stall_id_valid", {31'h0, id_valid}, 32'h1);
        check_eq("stall_buffered", 32'(sb_q.size()), 32'd2);
        check_eq("stall_head_pc", id_pc, 32'h0);
        @(posedge clk);
        #1;
        pop_log.delete();
        id_ready = 1'b1;
        wait_log(2, "drain_timeout");
        check_eq("drain0", get_log(0), 32'h0);
        check_eq("drain1", get_log(1), 32'h4);

        // Redirect while two requests are in flight.
        @(posedge clk);
        #1 mem_lat = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mem_q.size() + 32'(imem_rsp_valid) == 2) found = 1'b1;
        end
        check_eq("two_outstanding", {31'h0, found}, 32'h1);
        redirect_pc    = 32'h0000_0100;
        redirect_valid = 1'b1;
        pop_log.delete();
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        wait_log(2, "redir_timeout");
        check_eq("redir0", get_log(0), 32'h100);
        check_eq("redir1", get_log(1), 32'h104);

        // Unaligned redirect target with single-cycle memory.
        mem_lat = 1;
        repeat (4) @(posedge clk);
        #2;
        redirect_pc    = 32'h0000_0203;
        redirect_valid = 1'b1;
        pop_log.delete();
        @(negedge clk);
        check_eq("redirT_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_eq("redirT_id_valid", {31'h0, id_valid}, 32'h0);
        @(posedge clk);
        #2 redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("redirT1_addr", imem_req_addr, 32'h200);
        check_eq("redirT1_valid", {31'h0, imem_req_valid}, 32'h1);
        wait_log(1, "align_timeout");
        check_eq("align0", get_log(0), 32'h200);

        // Memory not ready: address held, PC advances only on accept.
        @(posedge clk);
        #1 imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_addr", imem_req_addr, exp_addr);
        end
        check_eq("hold_valid", {31'h0, imem_req_valid}, 32'h1);
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        repeat (4) @(posedge clk);

        // PC wrap at the top of the address space.
        #1;
        redirect_pc    = 32'hFFFF_FFFC;
        redirect_valid = 1'b1;
        pop_log.delete();
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_log(2, "wrap_timeout");
        check_eq("wrap0", get_log(0), 32'hFFFF_FFFC);
        check_eq("wrap1", get_log(1), 32'h0);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
